adc_line_capture: RTL and testbench
===================================

// Module: adc_line_capture
// PURPOSE
//  Downstream consumer of the photodiode-line ADC interface. Waits for the AD_trig pulse, then
//  captures one line of PIXELS words from ADC_data on each rising edge of the 10 MHz ADC clock.
//  It buffers the line and lets the readout logic (SPI/host side) pop it word by word.
//  Runs entirely in the 200 MHz domain; the ADC clock is sampled as data.
// PARAMETERS
//  PIXELS   518   words per line; buffer depth
//  DATA_W   16    ADC word width
//  TIMEOUT  2000  200 MHz cycles allowed without an ADC clock edge in ARM/CAPTURE before abort
// PORTS
//  clk_200MHz_i   in   1       system clock, all logic rising-edge
//  rst_n_i        in   1       asynchronous, active-low reset
//  AD_trig_i      in   1       ADC trigger pulse; falling edge arms capture
//  clk_10M_adc_i  in   1       ADC sample clock, asynchronous; 2-FF synchronised internally
//  ADC_data_i     in   DATA_W  ADC word, stable around clk_10M_adc_i rising edge
//  rd_en_i        in   1       pop one pixel; honoured only while line_ready_o=1
//  line_ready_o   out  1       complete line held in buffer
//  pix_data_o     out  DATA_W  popped pixel
//  pix_valid_o    out  1       pix_data_o valid (1 cycle after accepted rd_en_i)
//  pix_last_o     out  1       with pix_valid_o on pixel PIXELS-1
//  line_cnt_o     out  16      completed lines, wraps 0xFFFF->0
//  timeout_o      out  1       1-cycle pulse on capture abort
//  overrun_o      out  1       sticky: trigger arrived while previous line unread
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, addresses 0; buffer contents not cleared.
//  Sync: clk_10M_adc_i through 2 FFs + edge-detect FF; ADC_data_i through matching 2-stage
//   delay so the word written equals ADC_data_i present at the synchronised edge.
//  AD_trig_i is 2-FF synchronised; falling edge detected on the synchronised copy.
//  States:
//   IDLE    : trig falling edge -> ARM. Trig edges in READY set overrun_o; line is kept.
//   ARM     : first ADC-clock rising edge -> CAPTURE; that edge's word is written to addr 0.
//   CAPTURE : each edge writes word at wr_addr, wr_addr+1. Write of addr PIXELS-1 -> READY,
//             line_ready_o=1 next cycle, line_cnt_o+1 same cycle.
//   READY   : rd_en_i pops rd_addr; pix_data_o/pix_valid_o 1 cycle later; rd_en_i with no
//             pending word ignored. Pop of PIXELS-1: pix_last_o=1 with its data, line_ready_o
//             drops in that same cycle, state -> IDLE.
//  Timeout: in ARM/CAPTURE a counter clears on every ADC edge; reaching TIMEOUT -> timeout_o
//   pulse, wr_addr=0, -> IDLE, line_cnt_o unchanged, line_ready_o stays 0.
//  rd_en_i outside READY: no effect, pix_valid_o stays 0.
//  Trig edge during ARM/CAPTURE: ignored (no restart).
//  Overrun: only reset clears it.
//  Addresses: $clog2(PIXELS) bits; never exceed PIXELS-1.
//  Async reset mid-capture or mid-readout: immediate IDLE; partial line discarded.
// STRUCTURE
//  adc_line_pkg: state enum {IDLE,ARM,CAPTURE,READY}, defaults PIXELS/DATA_W, ADDR_W function.
//  Sub-module line_buf_ram: simple dual-port, 1 write, 1 read port, 1-cycle registered read,
//   PIXELS x DATA_W, no reset on storage.
//  Top: synchronisers, edge detectors, FSM, timeout counter, address counters, line counter.
// TESTING
//  1 Nominal: trig pulse, 518 ADC edges with data=index -> line_ready_o=1, 518 pops return
//    0..517, pix_last_o on 517, line_cnt_o=1.
//  2 Timeout: trig, 100 edges, then clock stops -> timeout_o after 2000 cycles, IDLE,
//    line_cnt_o=0, next full line captures correctly from addr 0.
//  3 Overrun: complete line, no reads, second trig -> overrun_o=1, first line reads back intact.
//  4 Reset mid-capture: rst_n_i low at edge 300 -> outputs 0 immediately; new trig + 518 edges
//    -> correct line, line_cnt_o=1.
//  5 Read rules: rd_en_i held high whole READY -> 518 consecutive valid words, then pix_valid_o
//    0; rd_en_i in IDLE -> no pix_valid_o.
//  6 Wrap: preload/force 65535 lines -> next completed line gives line_cnt_o=0.

Source files
------------

// File: rtl/adc_line_pkg.sv
// Shared types and defaults for the photodiode-line ADC capture block.
package adc_line_pkg;

  localparam int PIXELS_DEF  = 518;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 2000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    READY   = 2'd3
  } state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/line_buf_ram.sv
// One-line pixel buffer: simple dual-port, registered read, storage never reset.
module line_buf_ram #(
  parameter int DEPTH  = 518,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port; only the output register is reset so the popped word reads 0 after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/adc_line_capture.sv
// Captures one triggered line of ADC words into a buffer and hands it to the readout side
// word by word; the ADC clock is oversampled as data in the 200 MHz domain.
module adc_line_capture
  import adc_line_pkg::*;
#(
  parameter int PIXELS  = PIXELS_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_200MHz_i,
  input  logic              rst_n_i,
  input  logic              AD_trig_i,
  input  logic              clk_10M_adc_i,
  input  logic [DATA_W-1:0] ADC_data_i,
  input  logic              rd_en_i,
  output logic              line_ready_o,
  output logic [DATA_W-1:0] pix_data_o,
  output logic              pix_valid_o,
  output logic              pix_last_o,
  output logic [15:0]       line_cnt_o,
  output logic              timeout_o,
  output logic              overrun_o
);

  localparam int ADDR_W = addr_w(PIXELS);
  localparam int TO_W   = addr_w(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  logic [2:0]        adc_clk_sync_r;
  logic [2:0]        trig_sync_r;
  logic [DATA_W-1:0] data_d1_r, data_d2_r;
  logic              adc_edge_s, trig_fall_s;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] wr_addr_r, rd_addr_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic              we_s, rd_acc_s, to_hit_s, busy_s;
  logic              line_ready_r, pix_valid_r, pix_last_r, timeout_r, overrun_r;
  logic [15:0]       line_cnt_r;

  // Synchronisers; data delay matches the clock path so the word lines up with its edge
  always_ff @(posedge clk_200MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      adc_clk_sync_r <= 3'b000;
      trig_sync_r    <= 3'b000;
      data_d1_r      <= '0;
      data_d2_r      <= '0;
    end else begin
      adc_clk_sync_r <= {adc_clk_sync_r[1:0], clk_10M_adc_i};
      trig_sync_r    <= {trig_sync_r[1:0], AD_trig_i};
      data_d1_r      <= ADC_data_i;
      data_d2_r      <= data_d1_r;
    end
  end

  assign adc_edge_s  = adc_clk_sync_r[1] & ~adc_clk_sync_r[2];
  assign trig_fall_s = ~trig_sync_r[1] & trig_sync_r[2];
  assign busy_s      = (state_r == ARM) || (state_r == CAPTURE);

  // Next-state and per-cycle strobes
  always_comb begin
    state_nxt_s = state_r;
    we_s        = 1'b0;
    rd_acc_s    = 1'b0;
    to_hit_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (trig_fall_s) state_nxt_s = ARM;
        else             state_nxt_s = IDLE;
      end
      ARM, CAPTURE: begin
        if (adc_edge_s) begin
          we_s = 1'b1;
          if (wr_addr_r == LAST_ADDR) state_nxt_s = READY;
          else                        state_nxt_s = CAPTURE;
        end else if (to_cnt_r == TO_LAST) begin
          to_hit_s    = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      READY: begin
        if (rd_en_i) begin
          rd_acc_s = 1'b1;
          if (rd_addr_r == LAST_ADDR) state_nxt_s = IDLE;
          else                        state_nxt_s = READY;
        end else begin
          state_nxt_s = READY;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, address/timeout/line counters and registered status outputs
  always_ff @(posedge clk_200MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r      <= IDLE;
      wr_addr_r    <= '0;
      rd_addr_r    <= '0;
      to_cnt_r     <= '0;
      line_cnt_r   <= 16'd0;
      line_ready_r <= 1'b0;
      pix_valid_r  <= 1'b0;
      pix_last_r   <= 1'b0;
      timeout_r    <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      line_ready_r <= (state_nxt_s == READY);
      pix_valid_r  <= rd_acc_s;
      pix_last_r   <= rd_acc_s && (rd_addr_r == LAST_ADDR);
      timeout_r    <= to_hit_s;

      if (to_hit_s)       wr_addr_r <= '0;
      else if (we_s)      wr_addr_r <= (wr_addr_r == LAST_ADDR) ? '0 : wr_addr_r + ADDR_W'(1);
      else                wr_addr_r <= wr_addr_r;

      if (rd_acc_s)       rd_addr_r <= (rd_addr_r == LAST_ADDR) ? '0 : rd_addr_r + ADDR_W'(1);
      else                rd_addr_r <= rd_addr_r;

      if (busy_s && !adc_edge_s && !to_hit_s) to_cnt_r <= to_cnt_r + TO_W'(1);
      else                                    to_cnt_r <= '0;

      if (we_s && (wr_addr_r == LAST_ADDR)) line_cnt_r <= line_cnt_r + 16'd1;
      else                                  line_cnt_r <= line_cnt_r;

      // A new trigger while the line is unread is flagged but never overwrites it
      if ((state_r == READY) && trig_fall_s) overrun_r <= 1'b1;
      else                                   overrun_r <= overrun_r;
    end
  end

  line_buf_ram #(
    .DEPTH (PIXELS),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_line_buf_ram (
    .clk    (clk_200MHz_i),
    .rst_n  (rst_n_i),
    .we     (we_s),
    .wr_addr(wr_addr_r),
    .wr_data(data_d2_r),
    .re     (rd_acc_s),
    .rd_addr(rd_addr_r),
    .rd_data(pix_data_o)
  );

  assign line_ready_o = line_ready_r;
  assign pix_valid_o  = pix_valid_r;
  assign pix_last_o   = pix_last_r;
  assign line_cnt_o   = line_cnt_r;
  assign timeout_o    = timeout_r;
  assign overrun_o    = overrun_r;

endmodule

// File: tb/tb_adc_line_capture.sv
// Directed bench for adc_line_capture: table of line captures plus hand-written corner sequences.
module tb_adc_line_capture;

  localparam int PIX = 518;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic        adc_clk = 1'b0;
  logic [15:0] adc_data = 16'd0;
  logic        rd_en = 1'b0;
  logic        line_ready, pix_valid, pix_last, timeout, overrun;
  logic [15:0] pix_data, line_cnt;

  int total = 0;
  int bad   = 0;

  adc_line_capture dut (
    .clk_200MHz_i (clk),
    .rst_n_i      (rst_n),
    .AD_trig_i    (trig),
    .clk_10M_adc_i(adc_clk),
    .ADC_data_i   (adc_data),
    .rd_en_i      (rd_en),
    .line_ready_o (line_ready),
    .pix_data_o   (pix_data),
    .pix_valid_o  (pix_valid),
    .pix_last_o   (pix_last),
    .line_cnt_o   (line_cnt),
    .timeout_o    (timeout),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] base;
    int          edges;
    bit          abort;
    logic [15:0] exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_trig();
    @(negedge clk); trig = 1'b1;
    repeat (4) @(negedge clk);
    trig = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Each ADC period is 8 system cycles; the word changes while the ADC clock is low
  task automatic send_edges(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      adc_data = base + 16'(i);
      adc_clk  = 1'b0;
      repeat (4) @(negedge clk);
      adc_clk = 1'b1;
      repeat (4) @(negedge clk);
    end
    adc_clk = 1'b0;
  endtask

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (line_ready === 1'b1) seen = 1'b1;
    end
    chk("line_ready_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic read_line(input logic [15:0] base);
    int errs = 0;
    @(negedge clk); rd_en = 1'b1;
    for (int i = 0; i < PIX; i++) begin
      @(negedge clk);
      if (pix_valid !== 1'b1 || pix_data !== base + 16'(i) ||
          pix_last !== (i == PIX - 1) || line_ready !== (i != PIX - 1)) begin
        errs++;
      end
    end
    @(negedge clk);
    chk("valid_after_last", {31'd0, pix_valid}, 32'd0);
    rd_en = 1'b0;
    chk("line_word_errors", errs, 32'd0);
  endtask

  initial begin
    vec_t vecs[4];
    vecs[0] = '{16'h0000, PIX, 1'b0, 16'd1};
    vecs[1] = '{16'h0100, 100, 1'b1, 16'd1};
    vecs[2] = '{16'h8000, PIX, 1'b0, 16'd2};
    vecs[3] = '{16'hFF00, PIX, 1'b0, 16'd3};

    repeat (3) @(negedge clk);
    chk("rst_line_ready", {31'd0, line_ready}, 32'd0);
    chk("rst_pix_valid",  {31'd0, pix_valid},  32'd0);
    chk("rst_pix_data",   {16'd0, pix_data},   32'd0);
    chk("rst_line_cnt",   {16'd0, line_cnt},   32'd0);
    chk("rst_timeout",    {31'd0, timeout},    32'd0);
    chk("rst_overrun",    {31'd0, overrun},    32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Table: nominal lines, an aborted capture, and a recovery line from address 0
    for (int v = 0; v < 4; v++) begin
      pulse_trig();
      send_edges(vecs[v].edges, vecs[v].base);
      if (vecs[v].abort) begin
        int lat = 0;
        bit seen = 1'b0;
        for (int k = 1; k <= 2200 && !seen; k++) begin
          @(negedge clk);
          if (timeout === 1'b1) begin
            seen = 1'b1;
            lat  = k;
          end
        end
        chk("timeout_seen", {31'd0, seen}, 32'd1);
        chk("timeout_latency_ok", {31'd0, (lat >= 1990 && lat <= 2010)}, 32'd1);
        @(negedge clk);
        chk("timeout_one_cycle", {31'd0, timeout}, 32'd0);
        chk("abort_line_ready", {31'd0, line_ready}, 32'd0);
        chk("abort_line_cnt", {16'd0, line_cnt}, {16'd0, vecs[v].exp_cnt});
      end else begin
        wait_ready();
        chk("line_cnt", {16'd0, line_cnt}, {16'd0, vecs[v].exp_cnt});
        read_line(vecs[v].base);
      end
    end

    // Overrun: second trigger while a line is waiting keeps the line intact
    pulse_trig();
    send_edges(PIX, 16'h1234);
    wait_ready();
    chk("pre_overrun", {31'd0, overrun}, 32'd0);
    pulse_trig();
    send_edges(5, 16'hDEAD);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    chk("overrun_line_kept", {31'd0, line_ready}, 32'd1);
    chk("overrun_line_cnt", {16'd0, line_cnt}, 32'd4);
    read_line(16'h1234);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);

    // rd_en in IDLE produces nothing
    begin
      int spurious = 0;
      @(negedge clk); rd_en = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (pix_valid !== 1'b0) spurious++;
      end
      rd_en = 1'b0;
      chk("idle_rd_no_valid", spurious, 32'd0);
    end

    // Reset in the middle of a capture
    pulse_trig();
    send_edges(300, 16'h5000);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrst_line_cnt", {16'd0, line_cnt}, 32'd0);
    chk("midrst_overrun",  {31'd0, overrun},  32'd0);
    chk("midrst_ready",    {31'd0, line_ready}, 32'd0);
    chk("midrst_valid",    {31'd0, pix_valid}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse_trig();
    send_edges(PIX, 16'h6000);
    wait_ready();
    chk("post_rst_line_cnt", {16'd0, line_cnt}, 32'd1);
    read_line(16'h6000);

    // Line counter wraps from 0xFFFF to 0
    @(negedge clk);
    force dut.line_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut.line_cnt_r;
    @(negedge clk);
    chk("wrap_preload", {16'd0, line_cnt}, 32'h0000FFFF);
    pulse_trig();
    send_edges(PIX, 16'h0042);
    wait_ready();
    chk("wrap_line_cnt", {16'd0, line_cnt}, 32'd0);
    read_line(16'h0042);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
